// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is split into SLICE-bit stages, one register per stage.
// Latency STAGES cycles, throughput 1/cycle; a stalled output freezes every stage and drops in_ready.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cf,
  output logic             of,
  output logic             sf,
  output logic             zf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("addsub_pipe: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  logic             advance;
  logic             sub_op;
  logic [WIDTH-1:0] b_prep;
  logic             c_prep;

  // Pipeline state; stage k holds the beat after slice k has been resolved.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] z_q;
  logic [STAGES-1:0] sub_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  // Per-stage inputs and next-state values.
  logic [STAGES-1:0] in_v;
  logic [STAGES-1:0] in_c;
  logic [STAGES-1:0] in_z;
  logic [STAGES-1:0] in_sub;
  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic [SLICE:0]    sum  [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [STAGES-1:0] z_nxt;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + carry; SBB's borrow-in becomes an inverted carry-in.
  assign sub_op = op[0];
  assign b_prep = sub_op ? ~b : b;

  always_comb begin
    c_prep = 1'b0;
    case (op_e'(op))
      OP_ADD: c_prep = 1'b0;
      OP_SUB: c_prep = 1'b1;
      OP_ADC: c_prep = cin;
      OP_SBB: c_prep = ~cin;
      default: c_prep = 1'b0;
    endcase
  end

  always_comb begin
    in_v      = '0;
    in_c      = '0;
    in_z      = '0;
    in_sub    = '0;
    z_nxt     = '0;
    for (int k = 0; k < STAGES; k++) begin
      in_a[k]  = '0;
      in_b[k]  = '0;
      in_s[k]  = '0;
      sum[k]   = '0;
      s_nxt[k] = '0;
    end

    in_v[0]   = in_valid;
    in_c[0]   = c_prep;
    in_z[0]   = 1'b1;
    in_sub[0] = sub_op;
    in_a[0]   = a;
    in_b[0]   = b_prep;
    in_s[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k]   = vld_q[k-1];
      in_c[k]   = c_q[k-1];
      in_z[k]   = z_q[k-1];
      in_sub[k] = sub_q[k-1];
      in_a[k]   = a_q[k-1];
      in_b[k]   = b_q[k-1];
      in_s[k]   = s_q[k-1];
    end

    // Zero detection is AND-accumulated slice by slice so zf is ready with the last stage.
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, in_a[k][k*SLICE +: SLICE]}
             + {1'b0, in_b[k][k*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, in_c[k]};
      s_nxt[k] = in_s[k];
      s_nxt[k][k*SLICE +: SLICE] = sum[k][SLICE-1:0];
      z_nxt[k] = in_z[k] && (sum[k][SLICE-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      z_q   <= '0;
      sub_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= in_v[k];
        c_q[k]   <= sum[k][SLICE];
        z_q[k]   <= z_nxt[k];
        sub_q[k] <= in_sub[k];
        a_q[k]   <= in_a[k];
        b_q[k]   <= in_b[k];
        s_q[k]   <= s_nxt[k];
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign s         = s_q[LAST];
  assign cf        = c_q[LAST] ^ sub_q[LAST];
  assign sf        = s_q[LAST][WIDTH-1];
  assign zf        = z_q[LAST];
  // b_q carries the already-inverted operand, so this is the plain same-sign overflow rule.
  assign of        = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                  && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
